// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file: two combinational read ports,
// two write ports (port 1 wins on collision), optional bypass, hardware clear.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we0,
    input  logic [AW-1:0]   waddr0,
    input  logic [XLEN-1:0] wdata0,
    input  logic            we1,
    input  logic [AW-1:0]   waddr1,
    input  logic [XLEN-1:0] wdata1,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    output logic            ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    state_e          state_q, state_d;
    logic [AW:0]     clr_cnt_q, clr_cnt_d;
    logic            ready_q, ready_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        regs_d    = regs_q;
        case (state_q)
            CLEAR: begin
                regs_d[clr_cnt_q[AW-1:0]] = '0;
                clr_cnt_d = clr_cnt_q + CNT_ONE;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Port 1 is applied last so it overwrites port 0 on an address collision.
                if (we0 && !(ZERO_REG && waddr0 == '0)) begin
                    regs_d[waddr0] = wdata0;
                end
                if (we1 && !(ZERO_REG && waddr1 == '0)) begin
                    regs_d[waddr1] = wdata1;
                end
            end
            default: state_d = CLEAR;
        endcase
        ready_d = (state_d == RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    // NOTE: the storage array has no reset term; the clear sweep zeroes it, and
    // a reset edge itself must leave the contents untouched.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            regs_q <= regs_d;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] data;
        data = regs_q[addr];
        if (state_q != RUN) begin
            data = '0;
        end else if (ZERO_REG && addr == '0) begin
            data = '0;
        end else if (BYPASS && we1 && waddr1 == addr) begin
            data = wdata1;
        end else if (BYPASS && we0 && waddr0 == addr) begin
            data = wdata0;
        end
        return data;
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (bypass, hardwired r0) and an
// alternate one (no bypass, writable r0) share stimulus and a reference model.
module tb_regfile_mp;

    localparam int NREGS = 32;

    logic        clk;
    logic        rst_n;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1, raddr1, raddr2;
    logic [31:0] wdata0, wdata1;
    logic [31:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;
    logic        ready_a, ready_b;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_a [NREGS];
    logic [31:0] mem_b [NREGS];
    int          clr_edges = 0;

    regfile_mp u_dut (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .rdata1(rdata1_a),
        .raddr2(raddr2), .rdata2(rdata2_a),
        .ready(ready_a)
    );

    regfile_mp #(.BYPASS(1'b0), .ZERO_REG(1'b0)) u_alt (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .rdata1(rdata1_b),
        .raddr2(raddr2), .rdata2(rdata2_b),
        .ready(ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one clock edge, applied to both configurations.
    task automatic model_edge();
        if (!rst_n) begin
            clr_edges = 0;
        end else if (clr_edges < NREGS) begin
            mem_a[clr_edges] = 32'h0;
            mem_b[clr_edges] = 32'h0;
            clr_edges++;
        end else begin
            if (we0 && waddr0 != 5'd0) mem_a[waddr0] = wdata0;
            if (we1 && waddr1 != 5'd0) mem_a[waddr1] = wdata1;
            if (we0) mem_b[waddr0] = wdata0;
            if (we1) mem_b[waddr1] = wdata1;
        end
    endtask

    function automatic logic [31:0] exp_rd(input bit alt, input logic [4:0] a);
        if (clr_edges < NREGS) return 32'h0;
        if (!alt && a == 5'd0) return 32'h0;
        if (!alt && we1 && waddr1 == a) return wdata1;
        if (!alt && we0 && waddr0 == a) return wdata0;
        return alt ? mem_b[a] : mem_a[a];
    endfunction

    task automatic do_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] exp_ready;
        exp_ready = (clr_edges >= NREGS) ? 32'd1 : 32'd0;
        check({tag, "_ready_a"}, {31'b0, ready_a}, exp_ready);
        check({tag, "_ready_b"}, {31'b0, ready_b}, exp_ready);
        check({tag, "_rd1_a"}, rdata1_a, exp_rd(1'b0, raddr1));
        check({tag, "_rd2_a"}, rdata2_a, exp_rd(1'b0, raddr2));
        check({tag, "_rd1_b"}, rdata1_b, exp_rd(1'b1, raddr1));
        check({tag, "_rd2_b"}, rdata2_b, exp_rd(1'b1, raddr2));
    endtask

    task automatic clear_sweep(input string tag);
        for (int e = 1; e <= NREGS; e++) begin
            raddr1 = 5'($urandom_range(0, NREGS - 1));
            raddr2 = 5'($urandom_range(0, NREGS - 1));
            #1;
            check_outputs(tag);
            check({tag, "_rd_zero"}, rdata1_a | rdata2_a | rdata1_b | rdata2_b, 32'h0);
            do_edge();
            check({tag, "_ready_edge"}, {31'b0, ready_a}, (e == NREGS) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic read_all_zero(input string tag);
        we0 = 1'b0;
        we1 = 1'b0;
        for (int a = 0; a < NREGS; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(NREGS - 1 - a);
            #1;
            check({tag, "_a"}, rdata1_a | rdata2_a, 32'h0);
            check({tag, "_b"}, rdata1_b | rdata2_b, 32'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        rst_n  = 1'b0;
        we0    = 1'b0; waddr0 = 5'd0; wdata0 = 32'h0;
        we1    = 1'b0; waddr1 = 5'd0; wdata1 = 32'h0;
        raddr1 = 5'd0; raddr2 = 5'd0;

        // Reset for two edges.
        do_edge();
        do_edge();
        check_outputs("reset");

        // Release; a write is held during the whole sweep and must be ignored.
        rst_n  = 1'b1;
        we0    = 1'b1; waddr0 = 5'd31; wdata0 = 32'h0000_1234;
        clear_sweep("clear");
        read_all_zero("post_clear");

        // Single write with bypass versus delayed visibility.
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF; raddr1 = 5'd5; raddr2 = 5'd6;
        #1;
        check_outputs("wr5");
        check("wr5_bypass", rdata1_a, 32'hDEAD_BEEF);
        check("wr5_nobypass", rdata1_b, 32'h0);
        do_edge();
        we0 = 1'b0;
        #1;
        check_outputs("wr5_next");
        check("wr5_stored_b", rdata1_b, 32'hDEAD_BEEF);

        // Collision on the same address: port 1 wins.
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        check_outputs("coll");
        check("coll_bypass", rdata1_a, 32'h22);
        do_edge();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        check("coll_stored_a", rdata1_a, 32'h22);
        check("coll_stored_b", rdata1_b, 32'h22);

        // Different addresses: both stored.
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h33;
        we1 = 1'b1; waddr1 = 5'd8; wdata1 = 32'h44;
        raddr1 = 5'd7; raddr2 = 5'd8;
        #1;
        check_outputs("dual");
        do_edge();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        check_outputs("dual_next");
        check("dual_r7", rdata1_a, 32'h33);
        check("dual_r8", rdata2_a, 32'h44);

        // Write all ones to address 0.
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        check_outputs("r0_wr");
        check("r0_same_a", rdata1_a, 32'h0);
        do_edge();
        we0 = 1'b0;
        #1;
        check_outputs("r0_next");
        check("r0_after_a", rdata1_a, 32'h0);
        check("r0_after_b", rdata1_b, 32'hFFFF_FFFF);

        // Randomised traffic, addresses often folded to force collisions.
        for (int n = 0; n < 300; n++) begin
            we0    = 1'($urandom);
            we1    = 1'($urandom);
            waddr0 = 5'($urandom_range(0, (n % 2) ? 31 : 7));
            waddr1 = 5'($urandom_range(0, (n % 2) ? 31 : 7));
            raddr1 = 5'($urandom_range(0, (n % 2) ? 31 : 7));
            raddr2 = 5'($urandom_range(0, 31));
            wdata0 = $urandom;
            wdata1 = $urandom;
            #1;
            check_outputs("rand");
            do_edge();
        end

        // Store 0x55, reset in RUN, then reset again at clear count 10.
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h55; we1 = 1'b0;
        do_edge();
        we0 = 1'b0; raddr1 = 5'd9;
        #1;
        check("r9_before_reset", rdata1_a, 32'h55);
        rst_n = 1'b0;
        do_edge();
        check_outputs("rst_run");
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            do_edge();
            check_outputs("partial");
        end
        rst_n = 1'b0;
        do_edge();
        check_outputs("rst_mid");
        rst_n = 1'b1;
        clear_sweep("reclear");
        raddr1 = 5'd9;
        #1;
        check("r9_after_clear", rdata1_a, 32'h0);
        read_all_zero("post_reclear");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the single-cycle RISC-V datapath, successor to the fixed 32x32 two-read/one-write file. It adds configurable width and depth, a second write port with defined collision priority, optional write-to-read bypass, and a hardware clear sequencer. The clear sequencer zeroes every register after reset and replaces memory-file preload. It sits between decode (read addresses) and writeback (write ports), and gates the core's start through `ready`.

## Interface
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, register count; power of two, at least 2.
- `AW`, `$clog2(NREGS)`, address width (derived, not overridden).
- `BYPASS`, 1, 1 = same-cycle write data forwarded to reads.
- `ZERO_REG`, 1, 1 = register 0 hardwired to zero; writes to it dropped.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `we0` in 1: write enable for port 0.
- `waddr0` in AW: port 0 write address.
- `wdata0` in XLEN: port 0 write data.
- `we1` in 1: write enable for port 1; port 1 has priority over port 0.
- `waddr1` in AW: port 1 write address.
- `wdata1` in XLEN: port 1 write data.
- `raddr1` in AW: read port 1 address.
- `rdata1` out XLEN: read port 1 data, combinational.
- `raddr2` in AW: read port 2 address.
- `rdata2` out XLEN: read port 2 data, combinational.
- `ready` out 1: high once the clear sequence is complete.

## Operation
- FSM states: CLEAR and RUN.
- Reset: `rst_n`=0 at a rising edge sets state=CLEAR, `clr_cnt`=0, `ready`=0. Register contents are not touched on the reset edge itself.
- CLEAR, each edge with `rst_n`=1:
  - reg[`clr_cnt`] is set to 0 and `clr_cnt` increments.
  - When `clr_cnt`==NREGS-1 is written, state becomes RUN.
  - `we0`/`we1` are ignored.
  - `rdata1`/`rdata2` are forced to 0.
- RUN, writes:
  - `weN`=1 writes `wdataN` to reg[`waddrN`] at the edge.
  - With ZERO_REG=1, writes to address 0 are discarded.
  - If `we0`=`we1`=1 and `waddr0`==`waddr1`, only `wdata1` is stored.
  - Different addresses: both are written in the same cycle.
- RUN, reads (each port independently):
  - Address 0 with ZERO_REG=1 returns 0.
  - Otherwise, if BYPASS=1 and an enabled write targets the same address this cycle, the read returns that write data (port 1 data if both ports match).
  - Otherwise the read returns the stored register.
- BYPASS=0: reads return the pre-edge stored value; the write becomes visible the cycle after.
- `ready` = (state==RUN), registered.
- `clr_cnt` is AW+1 bits or saturates; no wrap into a second sweep.
- Reset asserted mid-CLEAR restarts the sweep at 0.
- Reset asserted in RUN re-enters CLEAR; every register is re-zeroed.

## Timing
- Clear latency: `ready` rises at the NREGS-th rising edge with `rst_n`=1 after reset release; 32 edges with defaults.
- Read latency: 0 cycles, combinational from address, bypass data and storage.
- Write latency: 1 edge to storage.
- Bypass path: `wdata` to `rdata` is combinational and adds to the critical path; BYPASS=0 removes it.
- Reset values: `ready`=0; `rdata1`/`rdata2`=0 throughout CLEAR; state=CLEAR; `clr_cnt`=0.

## Test plan
- Hold `rst_n`=0 for 2 edges, release:
  - `ready`=0 for 31 edges and 1 at edge 32.
  - `rdata1`=`rdata2`=0 throughout.
  - After `ready`, every address reads 0.
- RUN, `we0`=1, `waddr0`=5, `wdata0`=0xDEADBEEF, `raddr1`=5:
  - BYPASS=1: `rdata1`=0xDEADBEEF in the same cycle.
  - BYPASS=0: `rdata1`=0 this cycle and 0xDEADBEEF the next.
- Dual write collision, `we0`=`we1`=1, both to address 7, data 0x11 (port 0) and 0x22 (port 1):
  - Bypass read shows 0x22.
  - Stored value is 0x22.
  - The same cycle with addresses 7 and 8 stores both values.
- Write 0xFFFFFFFF to address 0:
  - `rdata1` at address 0 reads 0, both in the same cycle and afterwards (ZERO_REG=1).
  - With ZERO_REG=0, reads 0xFFFFFFFF the next cycle.
- Pulse `rst_n`=0 at clear count 10:
  - `ready` rises exactly 32 edges after the new release.
  - A register written to 0x55 before reset reads 0 after `ready`.
- Writes issued during CLEAR, `we0`=1, `waddr0`=31, `wdata0`=0x1234: ignored; address 31 reads 0 after `ready`.
